if_stage: RTL

Instruction-fetch stage directly upstream of the decode stage. It owns the PC and drives a variable-latency instruction-memory request/ready handshake. It presents if_inst, if_pc4, IF_ins_type and IF_ins_number to decode, holding them while decode stalls (cu_wpcir). It applies taken branch/jump redirects from decode (cu_branch, ID_new_pc) with MIPS single-delay-slot semantics.

---
 rtl/if_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding imem handshake and
// feeds decode through a registered output with a one-entry skid buffer.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cu_wpcir,
    input  logic        cu_branch,
    input  logic [31:0] ID_new_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic [3:0]  IF_ins_type,
    output logic [3:0]  IF_ins_number,
    output logic        fsm_state
);

    // Handshake: a request is issued while imem_req=1 and completes in the cycle
    // imem_ready=1; decode consumes the output register on every edge with cu_wpcir=0.
    typedef enum logic {FETCH = 1'b0, FULL = 1'b1} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, target, target_nx;
    logic        pend, pend_nx, drop, drop_nx;
    logic [31:0] skid_inst, skid_inst_nx, skid_pc4, skid_pc4_nx;
    logic [31:0] inst_nx, pc4_nx;
    logic        valid_nx;
    logic [3:0]  type_nx, number_nx;
    logic        consume, redir_now, redir_late;
    logic [31:0] next_pc;

    function automatic logic [3:0] ins_type(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (w == 32'd0)                        return 4'd0;
        else if (op == 6'h00)                  return (w[5:0] == 6'h08) ? 4'd2 : 4'd1;
        else if (op >= 6'h08 && op <= 6'h0F)   return 4'd3;
        else if (op == 6'h23)                  return 4'd4;
        else if (op == 6'h2B)                  return 4'd5;
        else if (op == 6'h04 || op == 6'h05)   return 4'd6;
        else if (op == 6'h02 || op == 6'h03)   return 4'd7;
        else                                   return 4'd15;
    endfunction

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign fsm_state = state;

    assign consume    = !cu_wpcir;
    assign redir_now  = cu_branch && consume && if_valid;
    assign redir_late = cu_branch && consume && !if_valid;
    // A late redirect accepted on the edge the delay slot arrives goes straight to the target.
    assign next_pc    = redir_late ? ID_new_pc : (pend ? target : pc + 32'd4);

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        target_nx    = target;
        pend_nx      = pend;
        drop_nx      = drop;
        skid_inst_nx = skid_inst;
        skid_pc4_nx  = skid_pc4;
        inst_nx      = if_inst;
        pc4_nx       = if_pc4;
        valid_nx     = if_valid;
        type_nx      = IF_ins_type;
        number_nx    = IF_ins_number;
        case (state)
            FETCH: begin
                if (redir_now) begin
                    pc_nx    = ID_new_pc;
                    drop_nx  = !imem_ready;
                    pend_nx  = 1'b0;
                    inst_nx  = NOP_INST;
                    valid_nx = 1'b0;
                    type_nx  = 4'd0;
                end else if (imem_ready && !drop) begin
                    pc_nx   = next_pc;
                    pend_nx = 1'b0;
                    if (consume) begin
                        inst_nx   = imem_rdata;
                        pc4_nx    = pc + 32'd4;
                        valid_nx  = 1'b1;
                        type_nx   = ins_type(imem_rdata);
                        number_nx = IF_ins_number + 4'd1;
                    end else begin
                        skid_inst_nx = imem_rdata;
                        skid_pc4_nx  = pc + 32'd4;
                        state_nx     = FULL;
                    end
                end else begin
                    if (imem_ready) drop_nx = 1'b0;
                    if (consume) begin
                        inst_nx  = NOP_INST;
                        valid_nx = 1'b0;
                        type_nx  = 4'd0;
                    end
                    if (redir_late) begin
                        target_nx = ID_new_pc;
                        pend_nx   = 1'b1;
                    end
                end
            end
            FULL: begin
                if (consume) begin
                    state_nx = FETCH;
                    if (redir_now) begin
                        // Skid holds the word after the delay slot: flush it.
                        pc_nx    = ID_new_pc;
                        pend_nx  = 1'b0;
                        inst_nx  = NOP_INST;
                        valid_nx = 1'b0;
                        type_nx  = 4'd0;
                    end else begin
                        if (redir_late) pc_nx = ID_new_pc;
                        inst_nx   = skid_inst;
                        pc4_nx    = skid_pc4;
                        valid_nx  = 1'b1;
                        type_nx   = ins_type(skid_inst);
                        number_nx = IF_ins_number + 4'd1;
                    end
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            target        <= 32'd0;
            pend          <= 1'b0;
            drop          <= 1'b0;
            skid_inst     <= NOP_INST;
            skid_pc4      <= 32'd0;
            if_inst       <= NOP_INST;
            if_pc4        <= 32'd0;
            if_valid      <= 1'b0;
            IF_ins_type   <= 4'd0;
            IF_ins_number <= 4'd0;
        end else begin
            state         <= state_nx;
            pc            <= pc_nx;
            target        <= target_nx;
            pend          <= pend_nx;
            drop          <= drop_nx;
            skid_inst     <= skid_inst_nx;
            skid_pc4      <= skid_pc4_nx;
            if_inst       <= inst_nx;
            if_pc4        <= pc4_nx;
            if_valid      <= valid_nx;
            IF_ins_type   <= type_nx;
            IF_ins_number <= number_nx;
        end
    end

endmodule
